wb_forward_pipe: RTL and testbench

Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage core and drives the destination-register, write-enable and result signals that the forwarding unit and register file consume. It is the producing end of the forwarding interface and decides which in-flight results are forwardable. It also exposes a pending-load flag for the hazard detection unit and a retired-instruction counter.

---
 rtl/wb_forward_pipe_if.sv | 37 +++
 rtl/wb_forward_pipe.sv | 92 +++++++++
 tb/tb_wb_forward_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_forward_pipe_if.sv
// Bundle of the EX-side inputs, data-memory signals and forwarding outputs of
// wb_forward_pipe. The slave modport is the pipe itself; master is the driver.
interface wb_forward_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] mem_read_data;
  logic            mem_stall;

  logic [4:0]       EX_MEM_rd;
  logic             EX_MEM_reg_write;
  logic [XLEN-1:0]  EX_MEM_fwd_data;
  logic             EX_MEM_load_pending;
  logic [4:0]       MEM_WB_rd;
  logic             MEM_WB_reg_write;
  logic [XLEN-1:0]  MEM_WB_fwd_data;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_result,
    output mem_read_data, mem_stall,
    input  EX_MEM_rd, EX_MEM_reg_write, EX_MEM_fwd_data, EX_MEM_load_pending,
    input  MEM_WB_rd, MEM_WB_reg_write, MEM_WB_fwd_data, retired_count
  );

  modport slave (
    input  ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_alu_result,
    input  mem_read_data, mem_stall,
    output EX_MEM_rd, EX_MEM_reg_write, EX_MEM_fwd_data, EX_MEM_load_pending,
    output MEM_WB_rd, MEM_WB_reg_write, MEM_WB_fwd_data, retired_count
  );
endinterface

// File: rtl/wb_forward_pipe.sv
// EX/MEM and MEM/WB pipeline registers plus forwarding-enable decode, a
// pending-load flag for hazard detection and a retired-instruction counter.
module wb_forward_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  wb_forward_pipe_if.slave bus
);

  logic            em_valid_q;
  logic [4:0]      em_rd_q;
  logic            em_reg_write_q;
  logic            em_mem_read_q;
  logic [XLEN-1:0] em_data_q;

  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic            wb_reg_write_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] wb_data_d;

  logic [CNT_W-1:0] cnt_q;

  // Loads take the memory read data; everything else writes back the ALU result.
  always_comb begin
    wb_data_d = em_data_q;
    if (em_mem_read_q) begin
      wb_data_d = bus.mem_read_data;
    end
  end

  // EX/MEM register: freezes while data memory is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      em_valid_q     <= 1'b0;
      em_rd_q        <= 5'd0;
      em_reg_write_q <= 1'b0;
      em_mem_read_q  <= 1'b0;
      em_data_q      <= '0;
    end else if (!bus.mem_stall) begin
      em_valid_q     <= bus.ex_valid;
      em_rd_q        <= bus.ex_rd;
      em_reg_write_q <= bus.ex_reg_write;
      em_mem_read_q  <= bus.ex_mem_read;
      em_data_q      <= bus.ex_alu_result;
    end
  end

  // MEM/WB register: a stall inserts a bubble instead of holding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
    end else if (bus.mem_stall) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= em_valid_q;
      wb_rd_q        <= em_rd_q;
      wb_reg_write_q <= em_reg_write_q;
      wb_data_q      <= wb_data_d;
    end
  end

  // Retired counter: counts whatever valid instruction sits in WB at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (wb_valid_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Output decode from registers only; rd==0 never enables a write or forward.
  assign bus.EX_MEM_rd           = em_rd_q;
  assign bus.EX_MEM_fwd_data     = em_data_q;
  assign bus.EX_MEM_reg_write    = em_valid_q & em_reg_write_q & ~em_mem_read_q &
                                   (em_rd_q != 5'd0);
  assign bus.EX_MEM_load_pending = em_valid_q & em_reg_write_q & em_mem_read_q &
                                   (em_rd_q != 5'd0);
  assign bus.MEM_WB_rd           = wb_rd_q;
  assign bus.MEM_WB_reg_write    = wb_valid_q & wb_reg_write_q & (wb_rd_q != 5'd0);
  assign bus.MEM_WB_fwd_data     = wb_data_q;
  assign bus.retired_count       = cnt_q;

endmodule

// File: tb/tb_wb_forward_pipe.sv
// Bench for wb_forward_pipe: directed scenarios plus a randomized run, all
// checked against an instruction-slot model. A second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_wb_forward_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] mem_read_data = '0;
  logic        mem_stall = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_forward_pipe_if #(.XLEN(32), .CNT_W(32)) bus ();
  wb_forward_pipe_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  assign bus.ex_valid       = ex_valid;
  assign bus.ex_rd          = ex_rd;
  assign bus.ex_reg_write   = ex_reg_write;
  assign bus.ex_mem_read    = ex_mem_read;
  assign bus.ex_alu_result  = ex_alu_result;
  assign bus.mem_read_data  = mem_read_data;
  assign bus.mem_stall      = mem_stall;
  assign bus4.ex_valid      = ex_valid;
  assign bus4.ex_rd         = ex_rd;
  assign bus4.ex_reg_write  = ex_reg_write;
  assign bus4.ex_mem_read   = ex_mem_read;
  assign bus4.ex_alu_result = ex_alu_result;
  assign bus4.mem_read_data = mem_read_data;
  assign bus4.mem_stall     = mem_stall;

  wb_forward_pipe #(.XLEN(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  wb_forward_pipe #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  // Observed pipeline outputs plus both counters, and the 4-bit instance's pipeline outputs.
  logic [112:0] obs;
  logic [76:0]  obs4;
  assign obs  = {bus.EX_MEM_rd, bus.EX_MEM_reg_write, bus.EX_MEM_fwd_data,
                 bus.EX_MEM_load_pending, bus.MEM_WB_rd, bus.MEM_WB_reg_write,
                 bus.MEM_WB_fwd_data, bus.retired_count, bus4.retired_count};
  assign obs4 = {bus4.EX_MEM_rd, bus4.EX_MEM_reg_write, bus4.EX_MEM_fwd_data,
                 bus4.EX_MEM_load_pending, bus4.MEM_WB_rd, bus4.MEM_WB_reg_write,
                 bus4.MEM_WB_fwd_data};

  // Model: the instruction occupying each stage slot and the number retired so far.
  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [31:0] d;
  } slot_t;

  slot_t       m_em;
  slot_t       m_wb;
  logic [31:0] m_ret;

  task automatic model_clear();
    m_em  = '0;
    m_wb  = '0;
    m_ret = '0;
  endtask

  task automatic model_edge();
    slot_t moved;
    if (!reset) begin
      model_clear();
      return;
    end
    if (m_wb.v) m_ret = m_ret + 32'd1;
    if (mem_stall) begin
      m_wb = '0;
    end else begin
      moved    = m_em;
      moved.mr = 1'b0;
      moved.d  = m_em.mr ? mem_read_data : m_em.d;
      m_wb     = moved;
      m_em     = '{v: ex_valid, rd: ex_rd, rw: ex_reg_write, mr: ex_mem_read,
                   d: ex_alu_result};
    end
  endtask

  function automatic logic [76:0] exp_pipe();
    logic em_fwd, em_lp, wb_we;
    em_fwd = m_em.v && m_em.rw && !m_em.mr && (m_em.rd != 0);
    em_lp  = m_em.v && m_em.rw && m_em.mr && (m_em.rd != 0);
    wb_we  = m_wb.v && m_wb.rw && (m_wb.rd != 0);
    return {m_em.rd, em_fwd, m_em.d, em_lp, m_wb.rd, wb_we, m_wb.d};
  endfunction

  function automatic logic [112:0] exp_vec();
    return {exp_pipe(), m_ret, m_ret[3:0]};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic [31:0] alu);
    ex_valid      = v;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_alu_result = alu;
  endtask

  task automatic test_reset();
    model_clear();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    cycle();
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0", obs);
    end
    reset = 1'b1;
    set_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'h11);
    cycle();
    set_ex(1'b1, 5'd4, 1'b1, 1'b1, 32'h22);
    cycle();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_fill got=%h want=%h", obs, exp_vec());
    end
    // Asynchronous reset mid-stall, between clock edges.
    mem_stall = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (obs !== '0 || obs4 !== '0) begin
      bad++;
      $display("FAIL reset_async got=%h/%h want=0", obs, obs4);
    end
    cycle();
    reset = 1'b1;
    mem_stall = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++;
    if (bus.retired_count !== 32'd0 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_alu();
    set_ex(1'b1, 5'd5, 1'b1, 1'b0, 32'h1234);
    cycle();
    total++;
    if (bus.EX_MEM_rd !== 5'd5 || bus.EX_MEM_reg_write !== 1'b1 ||
        bus.EX_MEM_fwd_data !== 32'h1234) begin
      bad++;
      $display("FAIL alu_exmem got=%h want rd=5 we=1 data=1234", obs);
    end
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++;
    if (bus.MEM_WB_rd !== 5'd5 || bus.MEM_WB_reg_write !== 1'b1 ||
        bus.MEM_WB_fwd_data !== 32'h1234) begin
      bad++;
      $display("FAIL alu_memwb got=%h want rd=5 we=1 data=1234", obs);
    end
    cycle();
    total++;
    if (bus.retired_count !== 32'd1 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL alu_retire got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_load();
    set_ex(1'b1, 5'd7, 1'b1, 1'b1, 32'h40);
    cycle();
    total++;
    if (bus.EX_MEM_reg_write !== 1'b0 || bus.EX_MEM_load_pending !== 1'b1 ||
        bus.EX_MEM_rd !== 5'd7 || bus.EX_MEM_fwd_data !== 32'h40) begin
      bad++;
      $display("FAIL load_exmem got=%h want we=0 pending=1 rd=7 addr=40", obs);
    end
    mem_read_data = 32'hDEADBEEF;
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++;
    if (bus.MEM_WB_fwd_data !== 32'hDEADBEEF || bus.MEM_WB_reg_write !== 1'b1 ||
        bus.MEM_WB_rd !== 5'd7 || bus.EX_MEM_load_pending !== 1'b0) begin
      bad++;
      $display("FAIL load_memwb got=%h want rd=7 we=1 data=deadbeef", obs);
    end
  endtask

  task automatic test_x0();
    logic [31:0] base;
    set_ex(1'b1, 5'd0, 1'b1, 1'b0, 32'h55);
    cycle();
    total++;
    if (bus.EX_MEM_reg_write !== 1'b0 || bus.EX_MEM_fwd_data !== 32'h55) begin
      bad++;
      $display("FAIL x0_exmem got=%h want we=0 data=55", obs);
    end
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++;
    if (bus.MEM_WB_reg_write !== 1'b0 || bus.MEM_WB_fwd_data !== 32'h55) begin
      bad++;
      $display("FAIL x0_memwb got=%h want we=0 data=55", obs);
    end
    base = m_ret;
    cycle();
    total++;
    if (bus.retired_count !== base + 32'd1) begin
      bad++;
      $display("FAIL x0_retire got=%0d want=%0d", bus.retired_count, base + 32'd1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    set_ex(1'b1, 5'd9, 1'b1, 1'b0, 32'h99);
    cycle();
    // A valid EX instruction during the stall must not be captured.
    mem_stall = 1'b1;
    set_ex(1'b1, 5'd3, 1'b1, 1'b0, 32'h33);
    base = m_ret;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (bus.EX_MEM_rd !== 5'd9 || bus.EX_MEM_reg_write !== 1'b1 ||
          bus.EX_MEM_fwd_data !== 32'h99 || bus.MEM_WB_reg_write !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h want em rd=9 we=1 data=99 wb we=0", i, obs);
      end
    end
    mem_stall = 1'b0;
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    total++;
    if (bus.MEM_WB_rd !== 5'd9 || bus.MEM_WB_reg_write !== 1'b1 ||
        bus.MEM_WB_fwd_data !== 32'h99) begin
      bad++;
      $display("FAIL stall_release got=%h want wb rd=9 we=1 data=99", obs);
    end
    cycle();
    total++;
    if (bus.retired_count !== base + 32'd1) begin
      bad++;
      $display("FAIL stall_retire got=%0d want=%0d", bus.retired_count, base + 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 5'd4, 1'b1, 1'b0, 32'hAAAA);
    cycle();
    set_ex(1'b1, 5'd4, 1'b1, 1'b0, 32'hBBBB);
    cycle();
    total++;
    if (bus.EX_MEM_rd !== 5'd4 || bus.MEM_WB_rd !== 5'd4 ||
        bus.EX_MEM_reg_write !== 1'b1 || bus.MEM_WB_reg_write !== 1'b1 ||
        bus.EX_MEM_fwd_data !== 32'hBBBB || bus.MEM_WB_fwd_data !== 32'hAAAA) begin
      bad++;
      $display("FAIL b2b_same_rd got=%h want both rd=4 we=1 em=bbbb wb=aaaa", obs);
    end
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_ex(1'b1, 5'($urandom_range(31)), 1'b1, 1'b0, $urandom);
      cycle();
    end
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    cycle();
    cycle();
    total++;
    if (bus4.retired_count !== 4'd1 || bus.retired_count !== 32'd17) begin
      bad++;
      $display("FAIL wrap got=%0d/%0d want=1/17", bus4.retired_count, bus.retired_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_ex(1'($urandom_range(1)), 5'($urandom_range(31)), 1'($urandom_range(1)),
             1'($urandom_range(1)), $urandom);
      mem_stall     = ($urandom_range(3) == 0);
      mem_read_data = $urandom;
      cycle();
      total++;
      if (obs !== exp_vec() || obs4 !== exp_pipe()) begin
        bad++;
        $display("FAIL random%0d got=%h/%h want=%h/%h", i, obs, obs4, exp_vec(), exp_pipe());
      end
    end
    mem_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_x0();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
